mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back formatter for the 5-stage MIPS core.
- Captures the MEM-stage result and the raw data-memory word, and performs load byte/halfword extraction with sign or zero extension.
- Drives the register file write port (waddr, wdata, we) one cycle later.
- Handles pipeline stall and flush, flags misaligned loads, and keeps a retired-instruction counter for the debug display.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  hold the current contents of the stage.
- flush  input  1  insert a bubble; takes priority over stall.
- in_valid  input  1  the MEM stage holds a real instruction.
- in_we  input  1  the instruction writes a register.
- in_waddr  input  5  destination register.
- in_alu_result  input  32  ALU result, or effective address for loads.
- in_mem_rdata  input  32  aligned 32-bit word read from data memory.
- in_mem_to_reg  input  1  1 = write back load data, 0 = write back ALU result.
- in_load_type  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 are treated as lw.
- waddr  output  5  register file write address.
- wdata  output  32  register file write data.
- we  output  1  register file write enable.
- wb_valid  output  1  the stage holds a real instruction.
- load_misaligned  output  1  the held instruction is a misaligned load.
- retired_count  output  CNT_W  number of valid instructions accepted into the stage.

Behaviour:
- Reset: on a rising edge with rst=1, all outputs go to 0 (waddr, wdata, we, wb_valid, load_misaligned, retired_count). rst overrides flush and stall.
- Update priority at each rising edge: rst > flush > stall > capture.
- flush: wb_valid, we and load_misaligned go to 0. waddr and wdata may hold; they are don't-care. retired_count is unchanged.
- stall (without flush): every register holds its value. we stays at its held value. The regfile rewriting the same value on repeated negedges is idempotent.
- Capture (no rst, flush or stall): all outputs load from the inputs, with one cycle of latency.
- Data selection at capture, with addr = in_alu_result[1:0] and little-endian byte lanes:
  - in_mem_to_reg=0: wdata = in_alu_result.
  - lw: wdata = in_mem_rdata.
  - lb / lbu: byte = in_mem_rdata[8*addr+7 : 8*addr], sign-extended / zero-extended.
  - lh / lhu: half = in_mem_rdata[16*addr[1]+15 : 16*addr[1]], sign-extended / zero-extended.
- Misalignment, applies only when in_mem_to_reg=1:
  - lh/lhu with addr[0]=1, or lw/reserved types with addr != 0, set load_misaligned=1.
  - The data is still computed per the lane rules above, but we is forced to 0.
- Write enable: we = in_valid & in_we & (in_waddr != 0) & ~misaligned. A write to r0 never asserts we.
- wb_valid = in_valid at capture, regardless of in_we.
- retired_count increments by 1 on every capture with in_valid=1, including misaligned loads. It wraps from 2^CNT_W−1 to 0 and never counts during stall, flush or reset.
- Timing contract with the regfile:
  - Outputs change only just after a rising edge.
  - The regfile samples them on the following falling edge, so a value written back is readable in the same cycle through the regfile bypass.
- There is no combinational path from any input to any output.

Test Plan:
- Reset: hold rst=1 for 2 cycles with stimulus active -> all outputs 0; release with in_valid=1, in_we=1, in_waddr=5, in_alu_result=0x1234, in_mem_to_reg=0 -> next edge waddr=5, wdata=0x00001234, we=1, retired_count=1.
- Loads: in_mem_rdata=0x80FF7F01 with lb at addr 1/2/3 -> wdata 0x0000007F / 0xFFFFFFFF / 0xFFFFFF80; lbu at addr 3 -> 0x00000080; lh at addr 2 -> 0xFFFF80FF; lhu at addr 2 -> 0x000080FF; lw -> 0x80FF7F01.
- Misaligned: lh at addr 1, then lw at addr 2, with in_we=1 -> load_misaligned=1, we=0, wb_valid=1, retired_count increments each time.
- r0 write: in_waddr=0, in_we=1, in_valid=1 -> we=0, wb_valid=1.
- Stall and flush: capture instruction A, then stall 3 cycles while inputs change to B -> outputs hold A and retired_count is unchanged. Assert flush together with stall -> wb_valid=0, we=0. Next capture of B -> outputs B, count +1.
- Counter wrap: preload retired_count near 0xFFFFFFFF via a bench force, or set CNT_W=4 and capture 16 valid instructions -> the count wraps to 0. Cycles with in_valid=0 do not increment.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-stage results in, register-file write port out.
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_we;
    logic [4:0]        in_waddr;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_rdata;
    logic              in_mem_to_reg;
    logic [2:0]        in_load_type;

    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              wb_valid;
    logic              load_misaligned;
    logic [CNT_W-1:0]  retired_count;

    // Driver side: the MEM stage / pipeline control and the regfile.
    modport master (
        output stall, flush, in_valid, in_we, in_waddr, in_alu_result,
               in_mem_rdata, in_mem_to_reg, in_load_type,
        input  waddr, wdata, we, wb_valid, load_misaligned, retired_count
    );

    // The MEM/WB stage itself.
    modport slave (
        input  stall, flush, in_valid, in_we, in_waddr, in_alu_result,
               in_mem_rdata, in_mem_to_reg, in_load_type,
        output waddr, wdata, we, wb_valid, load_misaligned, retired_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load byte/halfword extraction, misaligned
// load detection and a retired-instruction counter. All outputs are
// registered; the regfile samples them on the following falling edge.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic [1:0]        addr;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wdata_next;
    logic              misaligned;
    logic              we_next;

    logic [4:0]        waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              valid_q;
    logic              misaligned_q;
    logic [CNT_W-1:0]  count_q;

    assign addr = bus.in_alu_result[1:0];

    // Lane selection, extension and alignment check for the incoming load.
    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = 16'h0000;
        load_data  = bus.in_mem_rdata;
        misaligned = 1'b0;

        case (addr)
            2'd0:    byte_sel = bus.in_mem_rdata[7:0];
            2'd1:    byte_sel = bus.in_mem_rdata[15:8];
            2'd2:    byte_sel = bus.in_mem_rdata[23:16];
            default: byte_sel = bus.in_mem_rdata[31:24];
        endcase
        half_sel = addr[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];

        case (bus.in_load_type)
            LT_LB:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LT_LBU: load_data = {{(DATA_W-8){1'b0}}, byte_sel};
            LT_LH: begin
                load_data  = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misaligned = addr[0];
            end
            LT_LHU: begin
                load_data  = {{(DATA_W-16){1'b0}}, half_sel};
                misaligned = addr[0];
            end
            // lw and the reserved encodings
            default: begin
                load_data  = bus.in_mem_rdata;
                misaligned = (addr != 2'd0);
            end
        endcase

        // Alignment only matters when the load result is actually written back.
        misaligned = misaligned & bus.in_mem_to_reg & bus.in_valid;
        wdata_next = bus.in_mem_to_reg ? load_data : bus.in_alu_result;
        we_next    = bus.in_valid & bus.in_we & (bus.in_waddr != 5'd0) & ~misaligned;
    end

    // Stage register: reset, then flush, then stall-hold, otherwise capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else if (bus.flush) begin
            we_q         <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (!bus.stall) begin
            waddr_q      <= bus.in_waddr;
            wdata_q      <= wdata_next;
            we_q         <= we_next;
            valid_q      <= bus.in_valid;
            misaligned_q <= misaligned;
            if (bus.in_valid) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.waddr           = waddr_q;
    assign bus.wdata           = wdata_q;
    assign bus.we              = we_q;
    assign bus.wb_valid        = valid_q;
    assign bus.load_misaligned = misaligned_q;
    assign bus.retired_count   = count_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a 4-bit counter keeps the wrap short.
module tb_mem_wb_stage;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt = 0;

    mem_wb_stage_if #(.DATA_W(32), .CNT_W(CNT_W)) bus ();

    mem_wb_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] wa,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic m2r, input logic [2:0] lt);
        bus.in_valid      = v;
        bus.in_we         = w;
        bus.in_waddr      = wa;
        bus.in_alu_result = alu;
        bus.in_mem_rdata  = rd;
        bus.in_mem_to_reg = m2r;
        bus.in_load_type  = lt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
        check(tag, 32'(bus.retired_count), 32'(cnt % 16));
    endtask

    // Capture one load and check data, write enable and misalignment.
    task automatic load_case(input string tag, input logic [2:0] lt, input logic [31:0] alu,
                             input logic [31:0] exp_data, input logic exp_mis);
        drive(1'b1, 1'b1, 5'd3, alu, 32'h80FF7F01, 1'b1, lt);
        tick();
        cnt++;
        check({tag, ".wdata"}, bus.wdata, exp_data);
        check({tag, ".we"}, 32'(bus.we), 32'(!exp_mis));
        check({tag, ".mis"}, 32'(bus.load_misaligned), 32'(exp_mis));
        check({tag, ".valid"}, 32'(bus.wb_valid), 32'd1);
        check_count({tag, ".cnt"});
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h1111_2222, 1'b0, 3'b000);

        // Reset with live stimulus
        rst = 1'b1;
        tick();
        tick();
        check("rst.waddr", 32'(bus.waddr), 32'd0);
        check("rst.wdata", bus.wdata, 32'd0);
        check("rst.we", 32'(bus.we), 32'd0);
        check("rst.valid", 32'(bus.wb_valid), 32'd0);
        check("rst.mis", 32'(bus.load_misaligned), 32'd0);
        check("rst.cnt", 32'(bus.retired_count), 32'd0);

        rst = 1'b0;
        drive(1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 3'b000);
        tick();
        cnt++;
        check("alu.waddr", 32'(bus.waddr), 32'd5);
        check("alu.wdata", bus.wdata, 32'h0000_1234);
        check("alu.we", 32'(bus.we), 32'd1);
        check_count("alu.cnt");

        // Load lane extraction from 0x80FF7F01
        load_case("lb1",  3'b001, 32'h0000_1001, 32'h0000_007F, 1'b0);
        load_case("lb2",  3'b001, 32'h0000_1002, 32'hFFFF_FFFF, 1'b0);
        load_case("lb3",  3'b001, 32'h0000_1003, 32'hFFFF_FF80, 1'b0);
        load_case("lbu3", 3'b010, 32'h0000_1003, 32'h0000_0080, 1'b0);
        load_case("lbu0", 3'b010, 32'h0000_1000, 32'h0000_0001, 1'b0);
        load_case("lh2",  3'b011, 32'h0000_1002, 32'hFFFF_80FF, 1'b0);
        load_case("lh0",  3'b011, 32'h0000_1000, 32'h0000_7F01, 1'b0);
        load_case("lhu2", 3'b100, 32'h0000_1002, 32'h0000_80FF, 1'b0);
        load_case("lw0",  3'b000, 32'h0000_1000, 32'h80FF_7F01, 1'b0);
        load_case("rsv0", 3'b110, 32'h0000_1000, 32'h80FF_7F01, 1'b0);

        // Misaligned loads still retire but never write
        load_case("lh1",  3'b011, 32'h0000_1001, 32'h0000_7F01, 1'b1);
        load_case("lhu3", 3'b100, 32'h0000_1003, 32'h0000_80FF, 1'b1);
        load_case("lw2",  3'b000, 32'h0000_1002, 32'h80FF_7F01, 1'b1);
        load_case("rsv1", 3'b111, 32'h0000_1001, 32'h80FF_7F01, 1'b1);

        // Flush clears a held misaligned flag
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flmis.mis", 32'(bus.load_misaligned), 32'd0);
        check("flmis.valid", 32'(bus.wb_valid), 32'd0);
        check_count("flmis.cnt");

        // Write to r0
        drive(1'b1, 1'b1, 5'd0, 32'h0000_00AB, 32'h0, 1'b0, 3'b000);
        tick();
        cnt++;
        check("r0.we", 32'(bus.we), 32'd0);
        check("r0.valid", 32'(bus.wb_valid), 32'd1);
        check_count("r0.cnt");

        // Bubble and a valid no-write instruction
        drive(1'b0, 1'b1, 5'd4, 32'h0000_0044, 32'h0, 1'b0, 3'b000);
        tick();
        check("bub.we", 32'(bus.we), 32'd0);
        check("bub.valid", 32'(bus.wb_valid), 32'd0);
        check_count("bub.cnt");
        drive(1'b1, 1'b0, 5'd4, 32'h0000_0044, 32'h0, 1'b0, 3'b000);
        tick();
        cnt++;
        check("nowr.we", 32'(bus.we), 32'd0);
        check("nowr.valid", 32'(bus.wb_valid), 32'd1);
        check_count("nowr.cnt");

        // Stall holds A while inputs change to B
        drive(1'b1, 1'b1, 5'd9, 32'h0000_AAAA, 32'h0, 1'b0, 3'b000);
        tick();
        cnt++;
        check("A.wdata", bus.wdata, 32'h0000_AAAA);
        bus.stall = 1'b1;
        drive(1'b1, 1'b1, 5'd10, 32'h0000_BBBB, 32'h0, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl.waddr", 32'(bus.waddr), 32'd9);
            check("stl.wdata", bus.wdata, 32'h0000_AAAA);
            check("stl.we", 32'(bus.we), 32'd1);
            check("stl.valid", 32'(bus.wb_valid), 32'd1);
            check_count("stl.cnt");
        end
        bus.flush = 1'b1;
        tick();
        check("fl.valid", 32'(bus.wb_valid), 32'd0);
        check("fl.we", 32'(bus.we), 32'd0);
        check_count("fl.cnt");
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        tick();
        cnt++;
        check("B.waddr", 32'(bus.waddr), 32'd10);
        check("B.wdata", bus.wdata, 32'h0000_BBBB);
        check("B.we", 32'(bus.we), 32'd1);
        check_count("B.cnt");

        // Counter wrap with interleaved bubbles
        for (int i = 0; i < 36; i++) begin
            drive(i[0] == 1'b0, 1'b1, 5'd1, 32'(i), 32'h0, 1'b0, 3'b000);
            tick();
            if (i[0] == 1'b0) cnt++;
            check_count("wrap.cnt");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
